// File: rtl/md5_pkg.sv
// md5_pkg: types and constants shared by the MD5 padder and compression core.
`default_nettype none

package md5_pkg;

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_PAD   = 2'd1,
      S_SEND  = 2'd2,
      S_EXTRA = 2'd3
   } state_t;

   localparam int         BLOCK_BYTES = 64;
   localparam int         LEN_OFFSET  = 56;
   localparam logic [7:0] PAD_BYTE    = 8'h80;

   localparam logic [31:0] A0 = 32'h67452301;
   localparam logic [31:0] B0 = 32'hefcdab89;
   localparam logic [31:0] C0 = 32'h98badcfe;
   localparam logic [31:0] D0 = 32'h10325476;

endpackage

`default_nettype wire

// File: rtl/md5_block_padder.sv
// md5_block_padder: byte stream in, MD5-padded 512-bit blocks out (byte k at bits [8k+7:8k]).
`default_nettype none

module md5_block_padder
   import md5_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_final
);

   state_t             state_q, state_d;
   logic [6:0]         pos_q, pos_d;
   logic [6:0]         pos_inc;
   logic [LEN_W-1:0]   bitlen_q, bitlen_d;
   logic [7:0]         buf_q [BLOCK_BYTES];
   logic [7:0]         buf_d [BLOCK_BYTES];
   logic               final_q, final_d;
   logic               pend_q, pend_d;
   logic               padx_q, padx_d;

   assign pos_inc   = pos_q + 7'd1;
   assign in_ready  = (state_q == S_FILL);
   assign blk_valid = (state_q == S_SEND);
   assign blk_final = final_q;

   for (genvar k = 0; k < BLOCK_BYTES; k++) begin : g_pack
      assign blk_data[8*k +: 8] = buf_q[k];
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      bitlen_d = bitlen_q;
      final_d  = final_q;
      pend_d   = pend_q;
      padx_d   = padx_q;
      for (int i = 0; i < BLOCK_BYTES; i++) buf_d[i] = buf_q[i];

      case (state_q)
         S_FILL: begin
            // pos is always below 64 here: a full block leaves S_FILL on the same edge
            if (in_valid) begin
               buf_d[pos_q[5:0]] = in_data;
               pos_d             = pos_inc;
               bitlen_d          = bitlen_q + LEN_W'(8);
               if (in_last) begin
                  state_d = S_PAD;
               end else if (pos_inc == 7'(BLOCK_BYTES)) begin
                  final_d = 1'b0;
                  state_d = S_SEND;
               end
            end
         end
         S_PAD: begin
            if (pos_q < 7'(BLOCK_BYTES)) buf_d[pos_q[5:0]] = PAD_BYTE;
            if (pos_q < 7'(LEN_OFFSET)) begin
               for (int i = 0; i < 8; i++) buf_d[LEN_OFFSET + i] = bitlen_q[8*i +: 8];
               final_d = 1'b1;
            end else begin
               // no room for the length: it goes into a trailing extra block
               final_d = 1'b0;
               pend_d  = 1'b1;
               padx_d  = (pos_q == 7'(BLOCK_BYTES));
            end
            state_d = S_SEND;
         end
         S_SEND: begin
            if (blk_ready) begin
               if (!final_q && pend_q) begin
                  state_d = S_EXTRA;
               end else begin
                  for (int i = 0; i < BLOCK_BYTES; i++) buf_d[i] = 8'h00;
                  pos_d   = 7'd0;
                  final_d = 1'b0;
                  if (final_q) bitlen_d = '0;
                  state_d = S_FILL;
               end
            end
         end
         S_EXTRA: begin
            for (int i = 0; i < BLOCK_BYTES; i++) buf_d[i] = 8'h00;
            buf_d[0] = padx_q ? PAD_BYTE : 8'h00;
            for (int i = 0; i < 8; i++) buf_d[LEN_OFFSET + i] = bitlen_q[8*i +: 8];
            final_d = 1'b1;
            pend_d  = 1'b0;
            padx_d  = 1'b0;
            state_d = S_SEND;
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FILL;
         pos_q    <= 7'd0;
         bitlen_q <= '0;
         final_q  <= 1'b0;
         pend_q   <= 1'b0;
         padx_q   <= 1'b0;
         for (int i = 0; i < BLOCK_BYTES; i++) buf_q[i] <= 8'h00;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         bitlen_q <= bitlen_d;
         final_q  <= final_d;
         pend_q   <= pend_d;
         padx_q   <= padx_d;
         for (int i = 0; i < BLOCK_BYTES; i++) buf_q[i] <= buf_d[i];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_md5_block_padder.sv
// tb_md5_block_padder: directed vectors for the MD5 padder with hand-computed blocks.
`default_nettype none

module tb_md5_block_padder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [7:0]   in_data;
   logic         in_last;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_final;

   int vectors    = 0;
   int miscompares = 0;

   logic [7:0] msg [0:63];

   md5_block_padder #(.LEN_W(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_final (blk_final)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [511:0] b, input int j);
      return b[32*j +: 32];
   endfunction

   // Drives msg[0..n-1], one byte per cycle, in_last on the final byte.
   task automatic send_msg(input int n, input logic last);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = last && (i == n - 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
   endtask

   // Waits (bounded) for blk_valid, captures the block, then handshakes it.
   task automatic get_block(output logic [511:0] d, output logic f, output logic ok);
      ok = 1'b0;
      d  = '0;
      f  = 1'b0;
      for (int c = 0; c < 20 && !blk_valid; c++) begin
         @(posedge clk); #1;
      end
      if (blk_valid) begin
         ok = 1'b1;
         d  = blk_data;
         f  = blk_final;
         blk_ready = 1'b1;
         @(posedge clk); #1;
         blk_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      vectors++; if (blk_valid !== 1'b0) begin miscompares++; $display("FAIL reset_blk_valid got=%b exp=0", blk_valid); end
      vectors++; if (blk_final !== 1'b0) begin miscompares++; $display("FAIL reset_blk_final got=%b exp=0", blk_final); end
      vectors++; if (blk_data !== 512'h0) begin miscompares++; $display("FAIL reset_blk_data got=%h exp=0", blk_data); end
   endtask

   task automatic test_hello();
      string s;
      logic [511:0] d; logic f, ok;
      s = "Hello ENPM808! This is my MD5 implementation in verilog";
      for (int i = 0; i < 55; i++) msg[i] = s[i];
      send_msg(55, 1'b1);
      get_block(d, f, ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL hello_timeout got=%b exp=1", ok); end
      vectors++; if (word(d, 0) !== 32'h6c6c6548) begin miscompares++; $display("FAIL hello_w0 got=%h exp=6c6c6548", word(d, 0)); end
      vectors++; if (word(d, 12) !== 32'h69726576) begin miscompares++; $display("FAIL hello_w12 got=%h exp=69726576", word(d, 12)); end
      vectors++; if (word(d, 13) !== 32'h80676f6c) begin miscompares++; $display("FAIL hello_w13 got=%h exp=80676f6c", word(d, 13)); end
      vectors++; if (word(d, 14) !== 32'h000001b8) begin miscompares++; $display("FAIL hello_w14 got=%h exp=000001b8", word(d, 14)); end
      vectors++; if (word(d, 15) !== 32'h0) begin miscompares++; $display("FAIL hello_w15 got=%h exp=0", word(d, 15)); end
      vectors++; if (f !== 1'b1) begin miscompares++; $display("FAIL hello_final got=%b exp=1", f); end
   endtask

   task automatic test_one_byte(input string tag);
      logic [511:0] d, e; logic f, ok;
      msg[0] = 8'h61;
      send_msg(1, 1'b1);
      // Edge t accepted the byte; this is the S_PAD cycle.
      vectors++; if (blk_valid !== 1'b0) begin miscompares++; $display("FAIL %s_pad_cycle_valid got=%b exp=0", tag, blk_valid); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL %s_pad_cycle_ready got=%b exp=0", tag, in_ready); end
      @(posedge clk); #1;
      vectors++; if (blk_valid !== 1'b1) begin miscompares++; $display("FAIL %s_latency_valid got=%b exp=1", tag, blk_valid); end
      get_block(d, f, ok);
      e = '0;
      e[31:0]    = 32'h00008061;
      e[479:448] = 32'h00000008;
      vectors++; if (d !== e) begin miscompares++; $display("FAIL %s_block got=%h exp=%h", tag, d, e); end
      vectors++; if (f !== 1'b1) begin miscompares++; $display("FAIL %s_final got=%b exp=1", tag, f); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready_after got=%b exp=1", tag, in_ready); end
   endtask

   task automatic test_56_bytes();
      logic [511:0] d, e; logic f, ok;
      for (int i = 0; i < 56; i++) msg[i] = 8'(8'h30 + i);
      send_msg(56, 1'b1);
      get_block(d, f, ok);
      e = '0;
      for (int i = 0; i < 56; i++) e[8*i +: 8] = msg[i];
      e[8*56 +: 8] = 8'h80;
      vectors++; if (d !== e || ok !== 1'b1) begin miscompares++; $display("FAIL len56_blk1 got=%h exp=%h", d, e); end
      vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL len56_blk1_final got=%b exp=0", f); end
      vectors++; if (blk_valid !== 1'b0) begin miscompares++; $display("FAIL len56_extra_gap got=%b exp=0", blk_valid); end
      @(posedge clk); #1;
      vectors++; if (blk_valid !== 1'b1) begin miscompares++; $display("FAIL len56_extra_latency got=%b exp=1", blk_valid); end
      get_block(d, f, ok);
      e = '0;
      e[32*14 +: 32] = 32'h000001c0;
      vectors++; if (d !== e || ok !== 1'b1) begin miscompares++; $display("FAIL len56_blk2 got=%h exp=%h", d, e); end
      vectors++; if (f !== 1'b1) begin miscompares++; $display("FAIL len56_blk2_final got=%b exp=1", f); end
   endtask

   task automatic test_64_bytes();
      logic [511:0] d, e; logic f, ok;
      for (int i = 0; i < 64; i++) msg[i] = 8'(8'hA5 ^ (i * 7));
      send_msg(64, 1'b1);
      get_block(d, f, ok);
      e = '0;
      for (int i = 0; i < 64; i++) e[8*i +: 8] = msg[i];
      vectors++; if (d !== e || ok !== 1'b1) begin miscompares++; $display("FAIL len64_blk1 got=%h exp=%h", d, e); end
      vectors++; if (f !== 1'b0) begin miscompares++; $display("FAIL len64_blk1_final got=%b exp=0", f); end
      get_block(d, f, ok);
      e = '0;
      e[31:0]        = 32'h00000080;
      e[32*14 +: 32] = 32'h00000200;
      vectors++; if (d !== e || ok !== 1'b1) begin miscompares++; $display("FAIL len64_blk2 got=%h exp=%h", d, e); end
      vectors++; if (f !== 1'b1) begin miscompares++; $display("FAIL len64_blk2_final got=%b exp=1", f); end
   endtask

   task automatic test_backpressure_back_to_back();
      logic [511:0] d, held; logic f, hf, ok;
      msg[0] = 8'h01; msg[1] = 8'h02; msg[2] = 8'h03;
      send_msg(3, 1'b1);
      @(posedge clk); #1;
      held = blk_data;
      hf   = blk_final;
      for (int c = 0; c < 10; c++) begin
         vectors++;
         if (blk_valid !== 1'b1 || blk_data !== held || blk_final !== hf || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_c%0d got v=%b f=%b r=%b exp v=1 f=%b r=0 data_changed=%b", c, blk_valid, blk_final, in_ready, hf, blk_data !== held);
         end
         @(posedge clk); #1;
      end
      get_block(d, f, ok);
      vectors++; if (word(d, 0) !== 32'h80030201 || word(d, 14) !== 32'h18 || f !== 1'b1) begin
         miscompares++; $display("FAIL b2b_msgA got w0=%h w14=%h f=%b exp w0=80030201 w14=00000018 f=1", word(d, 0), word(d, 14), f);
      end
      for (int i = 0; i < 10; i++) msg[i] = 8'hEE;
      send_msg(10, 1'b1);
      get_block(d, f, ok);
      vectors++; if (word(d, 14) !== 32'h50 || word(d, 15) !== 32'h0 || word(d, 2) !== 32'h0080EEEE || f !== 1'b1) begin
         miscompares++; $display("FAIL b2b_msgB got w2=%h w14=%h f=%b exp w2=0080eeee w14=00000050 f=1", word(d, 2), word(d, 14), f);
      end
   endtask

   task automatic test_reset_mid_message();
      for (int i = 0; i < 30; i++) msg[i] = 8'h5A;
      send_msg(30, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (blk_data !== 512'h0 || in_ready !== 1'b1 || blk_valid !== 1'b0 || blk_final !== 1'b0) begin
         miscompares++; $display("FAIL async_reset got v=%b r=%b f=%b data_zero=%b exp v=0 r=1 f=0 data_zero=1", blk_valid, in_ready, blk_final, blk_data == 512'h0);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      vectors++; if (blk_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_block got=%b exp=0", blk_valid); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_one_byte("post_reset");
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; blk_ready = 1'b0;
      @(posedge clk); #1;
      test_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_hello();
      test_one_byte("one_byte");
      test_56_bytes();
      test_64_bytes();
      test_backpressure_back_to_back();
      test_reset_mid_message();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/md5_block_padder.md
# md5_block_padder

Byte-stream front end for the MD5 datapath. Accepts a message one byte per cycle, applies MD5 padding (0x80, zero fill, 64-bit little-endian bit length), and emits 512-bit blocks in the same packing the round modules consume: byte k of the block occupies bits [8k+7:8k], so word j is bits [32j+31:32j]. Sits between the host byte source and the iterative MD5 compression core, one block at a time.

## Interface

- LEN_W, 64, width of the bit-length counter. Fixed at 64 for MD5; the counter wraps modulo 2^64.
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  padder can accept a byte.
- in_data  in  8  message byte.
- in_last  in  1  final byte of the current message.
- blk_valid  out  1  blk_data holds a complete block.
- blk_ready  in  1  downstream accepts the block.
- blk_data  out  512  block, byte k at bits [8k+7:8k].
- blk_final  out  1  qualifies blk_valid: this is the last block of the message.

## Operation

- States: S_FILL, S_PAD, S_SEND, S_EXTRA.
- S_FILL: in_ready=1. On each in_valid&&in_ready, write in_data to byte position pos, pos+=1, bitlen+=8.
  - pos reaches 64 and in_last=0: go to S_SEND, blk_final=0.
  - in_last=1: go to S_PAD with p = new pos (1..64).
- S_PAD, one cycle:
  - p<64: byte p=0x80.
  - p<=55: bytes 56..63 = bitlen, little-endian; blk_final=1; go to S_SEND.
  - p>=56: blk_final=0, pending_extra=1, and pad_in_extra=(p==64); go to S_SEND.
- S_SEND: blk_valid=1, blk_data and blk_final held stable until blk_ready. On handshake:
  - If blk_final: clear the buffer, pos and bitlen; go to S_FILL.
  - Else if pending_extra: go to S_EXTRA.
  - Else: clear the buffer and pos, keep bitlen, go to S_FILL.
- S_EXTRA, one cycle: buffer all zeros, byte0=0x80 if pad_in_extra, bytes 56..63=bitlen. blk_final=1, clear pending_extra, go to S_SEND.
- Zero-length messages are not supported. Every message carries at least one byte.
- Buffer bytes not yet written in S_FILL are always zero, because the buffer is cleared on every return to S_FILL.

## Timing

- Reset values: state=S_FILL, in_ready=1, blk_valid=0, blk_final=0, blk_data=0, pos=0, bitlen=0, pending_extra=0.
- Reset asserted mid-message or mid-send discards everything immediately and asynchronously. No partial block is emitted.
- Throughput: one byte per cycle in S_FILL. in_ready=0 in all other states.
- Full non-final block: last byte accepted at edge t, blk_valid high from t+1.
- Final byte accepted at edge t: S_PAD during cycle t+1, blk_valid high from t+2.
- Extra block: available 2 cycles after the previous block's handshake (S_EXTRA, then S_SEND).
- After the final handshake at edge t, in_ready=1 from t+1. Next message bytes accepted from then on.
- blk_valid never deasserts without a handshake. blk_data must not change while blk_valid=1.

## Structure

- Shared package md5_pkg holds:
  - state enum;
  - BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80;
  - MD5 IV constants A0=67452301, B0=efcdab89, C0=98badcfe, D0=10325476, shared with the core.
- Single flat module, no sub-module. Buffer is 64 x 8-bit registers with a byte-write decoder.

## Test plan

- 55-byte ASCII "Hello ENPM808! This is my MD5 implementation in verilog" with in_last on byte 55 -> one block, blk_final=1.
  - word0=6c6c6548, word12=69726576, word13=80676f6c, word14=000001b8, word15=0.
- 1-byte message 0x61 -> one final block, word0=00008061, words1..13=0, word14=00000008, word15=0.
- 56-byte message -> block 1 non-final with byte56=0x80 and bytes57..63=0; block 2 final, all zero except word14=000001c0.
- 64-byte message -> block 1 holds the raw bytes, non-final; block 2 final with word0=00000080, word14=00000200.
- Backpressure: blk_ready held low 10 cycles on any block -> blk_valid, blk_data and blk_final stable, in_ready=0. Then two back-to-back messages produce independent bit lengths.
- Reset pulsed after 30 bytes of a message -> no block emitted, all outputs return to reset values. A following 1-byte message yields exactly the 1-byte vector above.
